// File: rtl/div_rem_rs.sv
// div_rem_rs: reservation station for the iterative divider (div, divu, rem, remu).
//   DEPTH entries wait for their two source operands. Wakeup comes from CDB
//   broadcasts, including a broadcast in the same cycle as the dispatch.
//   One divide is in flight at a time, driven by a small FSM:
//     IDLE  -> BUSY   issue the lowest-index ready entry
//     BUSY  -> DONE   divider completes
//     DONE  -> IDLE   result acknowledged
//     DRAIN          waits for a divide that was cancelled by a flush.
// Ports:
//   clk, rst                   clock; asynchronous active-high reset
//   dispatch_*                 entry allocation handshake plus operand tags and values
//   cdb_valid/cdb_pd/cdb_v     broadcast wakeup
//   fu_start/fu_rs1_v/fu_rs2_v/fu_funct3   issue to the divider
//   fu_valid/fu_rd_v           divider completion
//   result_*                   completed result, held until result_ack
//   flush                      branch-mispredict flush
module div_rem_rs #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_BITS      = 5,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [2:0]               dispatch_funct3,
  input  logic [PHYS_REG_BITS-1:0] dispatch_pd,
  input  logic [ROB_BITS-1:0]      dispatch_rob_idx,
  input  logic [PHYS_REG_BITS-1:0] dispatch_ps1,
  input  logic [PHYS_REG_BITS-1:0] dispatch_ps2,
  input  logic                     dispatch_ps1_rdy,
  input  logic                     dispatch_ps2_rdy,
  input  logic [31:0]              dispatch_rs1_v,
  input  logic [31:0]              dispatch_rs2_v,
  input  logic                     cdb_valid,
  input  logic [PHYS_REG_BITS-1:0] cdb_pd,
  input  logic [31:0]              cdb_v,
  output logic                     fu_start,
  output logic [31:0]              fu_rs1_v,
  output logic [31:0]              fu_rs2_v,
  output logic [2:0]               fu_funct3,
  input  logic                     fu_valid,
  input  logic [31:0]              fu_rd_v,
  output logic                     result_valid,
  input  logic                     result_ack,
  output logic [PHYS_REG_BITS-1:0] result_pd,
  output logic [ROB_BITS-1:0]      result_rob_idx,
  output logic [31:0]              result_v,
  input  logic                     flush
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0] state;

  logic [DEPTH-1:0]         e_vld, e_r1, e_r2;
  logic [2:0]               e_f3  [DEPTH];
  logic [PHYS_REG_BITS-1:0] e_pd  [DEPTH];
  logic [PHYS_REG_BITS-1:0] e_ps1 [DEPTH];
  logic [PHYS_REG_BITS-1:0] e_ps2 [DEPTH];
  logic [ROB_BITS-1:0]      e_rob [DEPTH];
  logic [31:0]              e_v1  [DEPTH];
  logic [31:0]              e_v2  [DEPTH];

  // Copy of the issued operation, kept for the whole divide
  logic [PHYS_REG_BITS-1:0] lat_pd;
  logic [ROB_BITS-1:0]      lat_rob;
  logic [2:0]               lat_f3;
  logic [31:0]              lat_rs1, lat_rs2, res_v;
  logic                     lat_dz;

  logic          free_found, iss_found;
  logic [IW-1:0] free_idx, iss_idx;

  // Scanning downward leaves the lowest matching index in the result.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!e_vld[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
      if (e_vld[i] && e_r1[i] && e_r2[i]) begin
        iss_found = 1'b1;
        iss_idx   = IW'(i);
      end
    end
  end

  logic disp_fire, cdb_hit;
  logic d_wk1, d_wk2, d_r1, d_r2;
  logic [31:0] d_v1, d_v2;

  assign dispatch_ready = free_found && !flush;
  assign disp_fire      = dispatch_valid && dispatch_ready;
  assign cdb_hit        = cdb_valid && (cdb_pd != '0);

  // Tag 0 is the hardwired zero register, so it never waits.
  assign d_wk1 = cdb_hit && (dispatch_ps1 == cdb_pd);
  assign d_wk2 = cdb_hit && (dispatch_ps2 == cdb_pd);
  assign d_r1  = dispatch_ps1_rdy || (dispatch_ps1 == '0) || d_wk1;
  assign d_r2  = dispatch_ps2_rdy || (dispatch_ps2 == '0) || d_wk2;
  assign d_v1  = (dispatch_ps1_rdy || dispatch_ps1 == '0) ? dispatch_rs1_v : cdb_v;
  assign d_v2  = (dispatch_ps2_rdy || dispatch_ps2 == '0) ? dispatch_rs2_v : cdb_v;

  // Issue depends only on registered entry state. A dispatch therefore
  // becomes visible to issue one cycle after it is accepted.
  assign fu_start  = (state == S_IDLE) && iss_found;
  assign fu_rs1_v  = fu_start ? e_v1[iss_idx] : lat_rs1;
  assign fu_rs2_v  = fu_start ? e_v2[iss_idx] : lat_rs2;
  assign fu_funct3 = fu_start ? e_f3[iss_idx] : lat_f3;

  assign result_valid   = (state == S_DONE);
  assign result_pd      = lat_pd;
  assign result_rob_idx = lat_rob;
  assign result_v       = res_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_vld <= '0;
      e_r1  <= '0;
      e_r2  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_f3[i]  <= '0;
        e_pd[i]  <= '0;
        e_ps1[i] <= '0;
        e_ps2[i] <= '0;
        e_rob[i] <= '0;
        e_v1[i]  <= '0;
        e_v2[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_vld[i] && !e_r1[i] && cdb_hit && e_ps1[i] == cdb_pd) begin
          e_r1[i] <= 1'b1;
          e_v1[i] <= cdb_v;
        end
        if (e_vld[i] && !e_r2[i] && cdb_hit && e_ps2[i] == cdb_pd) begin
          e_r2[i] <= 1'b1;
          e_v2[i] <= cdb_v;
        end
      end
      if (fu_start) e_vld[iss_idx] <= 1'b0;
      // free_idx never equals iss_idx: one slot is free, the other is valid.
      if (disp_fire) begin
        e_vld[free_idx] <= 1'b1;
        e_f3[free_idx]  <= dispatch_funct3;
        e_pd[free_idx]  <= dispatch_pd;
        e_rob[free_idx] <= dispatch_rob_idx;
        e_ps1[free_idx] <= dispatch_ps1;
        e_ps2[free_idx] <= dispatch_ps2;
        e_r1[free_idx]  <= d_r1;
        e_r2[free_idx]  <= d_r2;
        e_v1[free_idx]  <= d_v1;
        e_v2[free_idx]  <= d_v2;
      end
      if (flush) e_vld <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      lat_pd  <= '0;
      lat_rob <= '0;
      lat_f3  <= '0;
      lat_rs1 <= '0;
      lat_rs2 <= '0;
      lat_dz  <= 1'b0;
      res_v   <= '0;
    end else begin
      case (state)
        S_IDLE: if (fu_start) begin
          lat_pd  <= e_pd[iss_idx];
          lat_rob <= e_rob[iss_idx];
          lat_f3  <= e_f3[iss_idx];
          lat_rs1 <= e_v1[iss_idx];
          lat_rs2 <= e_v2[iss_idx];
          lat_dz  <= (e_v2[iss_idx] == '0);
          // The divider has already seen the start, so a flush in this
          // cycle must still wait for its completion.
          state   <= flush ? S_DRAIN : S_BUSY;
        end
        S_BUSY: begin
          if (flush) state <= fu_valid ? S_IDLE : S_DRAIN;
          else if (fu_valid) begin
            // A zero divisor gives the architectural result; funct3[1] selects rem/remu.
            res_v <= lat_dz ? (lat_f3[1] ? lat_rs1 : 32'hFFFF_FFFF) : fu_rd_v;
            state <= S_DONE;
          end
        end
        S_DONE:  if (flush || result_ack) state <= S_IDLE;
        // A completion that coincides with a flush still ends the drain,
        // because no later fu_valid will arrive.
        S_DRAIN: if (fu_valid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_rem_rs.sv
// tb_div_rem_rs: self-checking bench for div_rem_rs. The bench plays the role
// of the divider and uses an arithmetic reference for RISC-V div/rem.
module tb_div_rem_rs;
  localparam int PB = 6;
  localparam int RB = 5;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          dispatch_valid, dispatch_ready;
  logic [2:0]    dispatch_funct3;
  logic [PB-1:0] dispatch_pd, dispatch_ps1, dispatch_ps2;
  logic [RB-1:0] dispatch_rob_idx;
  logic          dispatch_ps1_rdy, dispatch_ps2_rdy;
  logic [31:0]   dispatch_rs1_v, dispatch_rs2_v;
  logic          cdb_valid;
  logic [PB-1:0] cdb_pd;
  logic [31:0]   cdb_v;
  logic          fu_start;
  logic [31:0]   fu_rs1_v, fu_rs2_v;
  logic [2:0]    fu_funct3;
  logic          fu_valid;
  logic [31:0]   fu_rd_v;
  logic          result_valid, result_ack;
  logic [PB-1:0] result_pd;
  logic [RB-1:0] result_rob_idx;
  logic [31:0]   result_v;
  logic          flush;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_rem_rs #(.PHYS_REG_BITS(PB), .ROB_BITS(RB), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_funct3(dispatch_funct3), .dispatch_pd(dispatch_pd),
    .dispatch_rob_idx(dispatch_rob_idx),
    .dispatch_ps1(dispatch_ps1), .dispatch_ps2(dispatch_ps2),
    .dispatch_ps1_rdy(dispatch_ps1_rdy), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .dispatch_rs1_v(dispatch_rs1_v), .dispatch_rs2_v(dispatch_rs2_v),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_v(cdb_v),
    .fu_start(fu_start), .fu_rs1_v(fu_rs1_v), .fu_rs2_v(fu_rs2_v), .fu_funct3(fu_funct3),
    .fu_valid(fu_valid), .fu_rd_v(fu_rd_v),
    .result_valid(result_valid), .result_ack(result_ack), .result_pd(result_pd),
    .result_rob_idx(result_rob_idx), .result_v(result_v),
    .flush(flush)
  );

  // RISC-V M-extension semantics, including the divide-by-zero and overflow cases.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
    case (f3)
      3'b100:  return ovf ? a : 32'(sa / sb);
      3'b101:  return a / b;
      3'b110:  return ovf ? 32'd0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  task automatic idle_inputs();
    dispatch_valid = 0; dispatch_funct3 = 0; dispatch_pd = 0; dispatch_rob_idx = 0;
    dispatch_ps1 = 0; dispatch_ps2 = 0; dispatch_ps1_rdy = 0; dispatch_ps2_rdy = 0;
    dispatch_rs1_v = 0; dispatch_rs2_v = 0;
    cdb_valid = 0; cdb_pd = 0; cdb_v = 0;
    fu_valid = 0; fu_rd_v = 0; result_ack = 0; flush = 0;
  endtask

  // Holds one dispatch until it is accepted, then returns on the following negedge.
  task automatic dispatch(input logic [2:0] f3, input logic [PB-1:0] pd, input logic [RB-1:0] rob,
                          input logic [PB-1:0] ps1, input logic r1, input logic [31:0] v1,
                          input logic [PB-1:0] ps2, input logic r2, input logic [31:0] v2);
    int k;
    dispatch_valid = 1; dispatch_funct3 = f3; dispatch_pd = pd; dispatch_rob_idx = rob;
    dispatch_ps1 = ps1; dispatch_ps1_rdy = r1; dispatch_rs1_v = v1;
    dispatch_ps2 = ps2; dispatch_ps2_rdy = r2; dispatch_rs2_v = v2;
    #1;
    k = 0;
    while (dispatch_ready !== 1'b1 && k < 40) begin
      @(negedge clk); #1; k++;
    end
    total++;
    if (dispatch_ready !== 1'b1) begin
      bad++; $display("FAIL dispatch_timeout ready=%b exp=1", dispatch_ready);
    end
    @(negedge clk);
    dispatch_valid = 0;
  endtask

  // Plays the divider for one operation and checks the issue, the result and the hold.
  task automatic run_fu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [PB-1:0] pd, input logic [RB-1:0] rob, input int hold,
                        input string tag);
    logic [31:0] exp;
    int k;
    exp = ref_op(f3, a, b);
    k = 0;
    while (fu_start !== 1'b1 && k < 40) begin
      @(negedge clk); k++;
    end
    total++;
    if (fu_start !== 1'b1) begin
      bad++; $display("FAIL %s start_timeout fu_start=%b exp=1", tag, fu_start);
      return;
    end
    total++;
    if ({fu_funct3, fu_rs1_v, fu_rs2_v} !== {f3, a, b}) begin
      bad++; $display("FAIL %s issue_ops got=%h/%h/%h exp=%h/%h/%h", tag, fu_funct3, fu_rs1_v, fu_rs2_v, f3, a, b);
    end
    @(negedge clk);
    total++;
    if (fu_start !== 1'b0 || {fu_funct3, fu_rs1_v, fu_rs2_v} !== {f3, a, b}) begin
      bad++; $display("FAIL %s busy_ops start=%b got=%h/%h/%h exp=0 %h/%h/%h", tag, fu_start, fu_funct3, fu_rs1_v, fu_rs2_v, f3, a, b);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    fu_valid = 1;
    fu_rd_v  = (b == 32'd0) ? $urandom : exp;
    @(negedge clk);
    fu_valid = 0;
    fu_rd_v  = $urandom;
    total++;
    if ({result_valid, result_v, result_pd, result_rob_idx} !== {1'b1, exp, pd, rob}) begin
      bad++; $display("FAIL %s result got=%b %h pd=%0d rob=%0d exp=1 %h pd=%0d rob=%0d", tag, result_valid, result_v, result_pd, result_rob_idx, exp, pd, rob);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (result_valid !== 1'b1 || result_v !== exp || result_pd !== pd || result_rob_idx !== rob || fu_start !== 1'b0) begin
        bad++; $display("FAIL %s hold%0d got=%b %h start=%b exp=1 %h start=0", tag, i, result_valid, result_v, fu_start, exp);
      end
    end
    result_ack = 1;
    @(negedge clk);
    result_ack = 0;
    total++;
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL %s after_ack result_valid=%b exp=0", tag, result_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (3) @(negedge clk);
    total++;
    if (fu_start !== 1'b0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL reset_ctl start=%b rv=%b exp=0 0", fu_start, result_valid);
    end
    total++;
    if ({result_pd, result_rob_idx, result_v} !== '0) begin
      bad++; $display("FAIL reset_result got=%0d %0d %h exp=0", result_pd, result_rob_idx, result_v);
    end
    total++;
    if ({fu_rs1_v, fu_rs2_v, fu_funct3} !== '0) begin
      bad++; $display("FAIL reset_fu got=%h %h %h exp=0", fu_rs1_v, fu_rs2_v, fu_funct3);
    end
    rst = 0;
    @(negedge clk);
    total++;
    if (dispatch_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got=%b exp=1", dispatch_ready);
    end
  endtask

  task automatic test_basic();
    dispatch(3'b100, 6'd12, 5'd3, 6'd1, 1'b1, 32'd100, 6'd2, 1'b1, 32'd7);
    total++;
    if (fu_start !== 1'b1) begin
      bad++; $display("FAIL basic_latency fu_start=%b exp=1", fu_start);
    end
    run_fu(3'b100, 32'd100, 32'd7, 6'd12, 5'd3, 2, "basic");
  endtask

  task automatic test_wakeup();
    dispatch(3'b110, 6'd20, 5'd4, 6'd3, 1'b1, 32'd10, 6'd5, 1'b0, 32'hDEAD);
    total++;
    if (fu_start !== 1'b0) begin
      bad++; $display("FAIL wakeup_early fu_start=%b exp=0", fu_start);
    end
    cdb_valid = 1; cdb_pd = 6'd5; cdb_v = 32'd3;
    @(negedge clk);
    cdb_valid = 0;
    run_fu(3'b110, 32'd10, 32'd3, 6'd20, 5'd4, 0, "wakeup");
    // The broadcast lands in the same cycle as the dispatch, and tag 0 keeps the value as supplied.
    cdb_valid = 1; cdb_pd = 6'd9; cdb_v = 32'd4;
    dispatch(3'b101, 6'd21, 5'd5, 6'd0, 1'b0, 32'd50, 6'd9, 1'b0, 32'hBEEF);
    cdb_valid = 0;
    run_fu(3'b101, 32'd50, 32'd4, 6'd21, 5'd5, 0, "samecyc");
  endtask

  task automatic test_divzero();
    dispatch(3'b101, 6'd22, 5'd6, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd0);
    run_fu(3'b101, 32'd9, 32'd0, 6'd22, 5'd6, 0, "divu0");
    dispatch(3'b111, 6'd23, 5'd7, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd0);
    run_fu(3'b111, 32'd9, 32'd0, 6'd23, 5'd7, 0, "remu0");
    dispatch(3'b110, 6'd24, 5'd8, 6'd1, 1'b1, 32'hFFFF_FFF0, 6'd2, 1'b1, 32'd0);
    run_fu(3'b110, 32'hFFFF_FFF0, 32'd0, 6'd24, 5'd8, 0, "rem0");
    dispatch(3'b100, 6'd25, 5'd9, 6'd1, 1'b1, 32'h8000_0000, 6'd2, 1'b1, 32'hFFFF_FFFF);
    run_fu(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 6'd25, 5'd9, 0, "ovf");
  endtask

  task automatic test_random();
    logic [2:0]    f3;
    logic [31:0]   a, b;
    logic [PB-1:0] pd;
    logic [RB-1:0] rob;
    for (int n = 0; n < 16; n++) begin
      f3  = 3'(4 + $urandom_range(0, 3));
      a   = $urandom;
      pd  = PB'($urandom_range(1, 63));
      rob = RB'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 100);
        default: b = $urandom;
      endcase
      dispatch(f3, pd, rob, PB'($urandom_range(1, 63)), 1'b1, a, PB'($urandom_range(1, 63)), 1'b1, b);
      run_fu(f3, a, b, pd, rob, $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_fill();
    logic [2:0]  f3 [D];
    logic [31:0] bv [D];
    logic [31:0] wv;
    wv = 32'd1000 + $urandom_range(0, 999);
    for (int i = 0; i < D; i++) begin
      f3[i] = 3'(4 + (i % 4));
      bv[i] = $urandom_range(1, 50);
      dispatch(f3[i], PB'(40 + i), RB'(10 + i), 6'd7, 1'b0, 32'h0, 6'd8, 1'b1, bv[i]);
    end
    #1;
    total++;
    if (dispatch_ready !== 1'b0 || fu_start !== 1'b0) begin
      bad++; $display("FAIL fill_full ready=%b start=%b exp=0 0", dispatch_ready, fu_start);
    end
    @(negedge clk);
    cdb_valid = 1; cdb_pd = 6'd7; cdb_v = wv;
    @(negedge clk);
    cdb_valid = 0;
    for (int i = 0; i < D; i++)
      run_fu(f3[i], wv, bv[i], PB'(40 + i), RB'(10 + i), 0, "fill_order");
  endtask

  task automatic test_hold();
    dispatch(3'b101, 6'd50, 5'd20, 6'd13, 1'b0, 32'h0, 6'd0, 1'b1, 32'd6);
    dispatch(3'b111, 6'd51, 5'd21, 6'd13, 1'b0, 32'h0, 6'd0, 1'b1, 32'd5);
    cdb_valid = 1; cdb_pd = 6'd13; cdb_v = 32'd77;
    @(negedge clk);
    cdb_valid = 0;
    run_fu(3'b101, 32'd77, 32'd6, 6'd50, 5'd20, 5, "hold_a");
    run_fu(3'b111, 32'd77, 32'd5, 6'd51, 5'd21, 0, "hold_b");
  endtask

  task automatic test_flush();
    dispatch(3'b100, 6'd30, 5'd6, 6'd1, 1'b1, 32'd1000, 6'd2, 1'b1, 32'd10);
    @(negedge clk);
    dispatch(3'b101, 6'd31, 5'd7, 6'd11, 1'b0, 32'h0, 6'd2, 1'b1, 32'd3);
    flush = 1;
    #1;
    total++;
    if (dispatch_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready got=%b exp=0", dispatch_ready);
    end
    @(negedge clk);
    flush = 0;
    cdb_valid = 1; cdb_pd = 6'd11; cdb_v = 32'd99;
    @(negedge clk);
    cdb_valid = 0;
    fu_valid = 1; fu_rd_v = 32'd100;
    @(negedge clk);
    fu_valid = 0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (result_valid !== 1'b0 || fu_start !== 1'b0) begin
        bad++; $display("FAIL flush_drain%0d rv=%b start=%b exp=0 0", i, result_valid, fu_start);
      end
      @(negedge clk);
    end
    dispatch(3'b110, 6'd32, 5'd8, 6'd1, 1'b1, 32'd47, 6'd2, 1'b1, 32'd5);
    run_fu(3'b110, 32'd47, 32'd5, 6'd32, 5'd8, 0, "after_flush");
  endtask

  task automatic test_reset_busy();
    dispatch(3'b101, 6'd33, 5'd9, 6'd1, 1'b1, 32'd64, 6'd2, 1'b1, 32'd8);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    fu_valid = 1; fu_rd_v = 32'd8;
    @(negedge clk);
    fu_valid = 0;
    total++;
    if (result_valid !== 1'b0 || fu_start !== 1'b0 || dispatch_ready !== 1'b1) begin
      bad++; $display("FAIL reset_busy rv=%b start=%b ready=%b exp=0 0 1", result_valid, fu_start, dispatch_ready);
    end
    @(negedge clk);
    total++;
    if (result_valid !== 1'b0) begin
      bad++; $display("FAIL reset_busy_late rv=%b exp=0", result_valid);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_divzero();
    test_random();
    test_fill();
    test_hold();
    test_flush();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_rem_rs.md
DIV_REM_RS -- requirements
Module: div_rem_rs

Interface
REQ-001 Parameter PHYS_REG_BITS, default 6, physical register tag width.
REQ-002 Parameter ROB_BITS, default 5, ROB index width.
REQ-003 Parameter DEPTH, default 4, number of station entries (power of 2, >=2).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 dispatch_valid / dispatch_ready  in / out  1  dispatch handshake; an entry is accepted when both are high.
REQ-007 dispatch_funct3  in  3  mult_div funct3 (div, divu, rem, remu only).
REQ-008 dispatch_pd  in  PHYS_REG_BITS  destination tag; dispatch_rob_idx  in  ROB_BITS.
REQ-009 dispatch_ps1, dispatch_ps2  in  PHYS_REG_BITS  source tags; dispatch_ps1_rdy, dispatch_ps2_rdy  in  1; dispatch_rs1_v, dispatch_rs2_v  in  32  values valid when rdy.
REQ-010 cdb_valid  in  1; cdb_pd  in  PHYS_REG_BITS; cdb_v  in  32  broadcast wakeup.
REQ-011 fu_start  out  1; fu_rs1_v, fu_rs2_v  out  32; fu_funct3  out  3  operands to divider.
REQ-012 fu_valid  in  1  one-cycle divider completion pulse; fu_rd_v  in  32  divider result.
REQ-013 result_valid  out  1; result_ack  in  1; result_pd  out  PHYS_REG_BITS; result_rob_idx  out  ROB_BITS; result_v  out  32.
REQ-014 flush  in  1  branch-mispredict flush.

Function
REQ-015 Each entry holds valid, funct3, pd, rob_idx, two source tags, two ready bits, and two 32-bit values.
REQ-016 dispatch_ready is high iff at least one entry is free and flush is low; the accepted entry goes to the lowest-index free entry.
REQ-017 Wakeup: when cdb_valid is high, any valid, not-ready source whose tag equals cdb_pd (and cdb_pd != 0) sets ready and captures cdb_v.
REQ-018 The same wakeup applies to a source being dispatched in the same cycle.
REQ-019 Tag 0 sources are always ready with value as supplied.
REQ-020 FSM states: IDLE, BUSY, DONE, DRAIN.
REQ-021 IDLE: if any valid entry has both sources ready, select the lowest index.
REQ-022 On that selection, assert fu_start for exactly one cycle with that entry's values and funct3, free the entry, latch pd/rob_idx/funct3/rs1_v and divisor-zero flag, and go to BUSY.
REQ-023 fu_rs1_v, fu_rs2_v and fu_funct3 are driven from the latched copy in BUSY, so they stay stable until fu_valid.
REQ-024 BUSY: on fu_valid, capture the result into result_v and go to DONE; fu_start stays low.
REQ-025 Divisor-zero correction: div/divu give 0xFFFFFFFF; rem/remu give the latched rs1 value; the fu_rd_v value is ignored.
REQ-026 Signed overflow (0x80000000 / 0xFFFFFFFF) passes fu_rd_v through unchanged.
REQ-027 DONE: result_valid is high, with result_pd, result_rob_idx and result_v held stable until result_ack; on ack go to IDLE.
REQ-028 No issue occurs in the same cycle as the ack.
REQ-029 flush: all entries are invalidated next cycle and dispatch in that cycle is dropped.
REQ-030 flush effect on the FSM: IDLE or DONE -> IDLE with result_valid low; BUSY -> DRAIN.
REQ-031 DRAIN: fu_start is low and result_valid is low; on fu_valid the result is discarded and the FSM goes to IDLE; flush in DRAIN stays in DRAIN.
REQ-032 At most one divide is outstanding at a time.
REQ-033 Outputs other than result_* and fu_* operands are combinational only from state; there is no combinational path from dispatch_valid to fu_start.

Reset
REQ-034 On rst: all entries invalid and FSM = IDLE.
REQ-035 On rst: fu_start = 0 and result_valid = 0.
REQ-036 On rst: result_pd, result_rob_idx, result_v, fu_rs1_v, fu_rs2_v and fu_funct3 = 0; dispatch_ready = 1 after release.
REQ-037 rst asserted mid-BUSY abandons the operation; any later fu_valid while in IDLE is ignored.

Verification
REQ-038 Dispatch div, rs1=100, rs2=7, both ready -> fu_start pulses next cycle; fu_valid with 14 -> result_valid, result_v=14, held until ack.
REQ-039 Dispatch rem with ps2=5 not ready; cdb_pd=5, cdb_v=3 the following cycle -> issue after wakeup; rs1=10 -> result_v=1.
REQ-040 divu with rs2=0, rs1=9 -> result_v=0xFFFFFFFF; remu with same operands -> result_v=9.
REQ-041 Fill DEPTH entries with unready sources -> dispatch_ready=0; single CDB wakeup of a shared tag readies all of them; issue proceeds in index order 0,1,2,3.
REQ-042 flush while BUSY -> entries cleared, DRAIN; the following fu_valid produces no result_valid; the next dispatch issues normally.
REQ-043 Hold result_ack low 5 cycles in DONE -> result_* stable, no new fu_start despite ready entries.
